// File: rtl/game_flow_ctrl.sv
// Game-flow state machine for the HEROE console: power/welcome/choose/game/win-lose/play-again.
// Keypad presses are edge-detected; a single-clock prescaler times the WL hold and the PA idle timeout.
module game_flow_ctrl #(
  parameter int CLK_HZ       = 27000000,
  parameter int WL_HOLD_S    = 10,
  parameter int PA_TIMEOUT_S = 30,
  parameter int KEY_W        = 5,
  parameter int KEY_PWR      = 13,
  parameter int KEY_ST       = 10,
  parameter int KEY_YES      = 15,
  parameter int KEY_NO       = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             keypad_pressed,
  input  logic [KEY_W-1:0] key,
  input  logic [1:0]       w_or_l,
  output logic [2:0]       estado,
  output logic [1:0]       result,
  output logic             state_chg,
  output logic [5:0]       secs,
  output logic             fsm_error
);

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_WLCM = 3'd1;
  localparam logic [2:0] S_CH   = 3'd2;
  localparam logic [2:0] S_GAME = 3'd3;
  localparam logic [2:0] S_WL   = 3'd4;
  localparam logic [2:0] S_PA   = 3'd5;

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_HZ - 1);
  localparam logic [5:0]    WL_LAST   = 6'(WL_HOLD_S - 1);
  localparam logic [5:0]    PA_LAST   = 6'(PA_TIMEOUT_S - 1);
  localparam bit            PA_TO_EN  = (PA_TIMEOUT_S != 0);

  logic          kp_q;
  logic [PW-1:0] presc;
  logic          press, tick, chg, err_set;
  logic          k_pwr, k_st, k_yes, k_no;
  logic          in_timed, nxt_timed;
  logic [2:0]    nxt;

  assign press = keypad_pressed & ~kp_q;
  assign k_pwr = press && (key == KEY_W'(KEY_PWR));
  assign k_st  = press && (key == KEY_W'(KEY_ST));
  assign k_yes = press && (key == KEY_W'(KEY_YES));
  assign k_no  = press && (key == KEY_W'(KEY_NO));
  assign tick  = (presc == PRESC_TOP);

  assign in_timed  = (estado == S_WL) || (estado == S_PA);
  assign nxt_timed = (nxt == S_WL) || (nxt == S_PA);
  assign chg       = (nxt != estado);

  always_comb begin
    nxt     = estado;
    err_set = (estado == S_GAME) && (w_or_l == 2'b11);
    if (estado > S_PA) begin
      nxt     = S_OFF;
      err_set = 1'b1;
    end else if (k_pwr) begin
      nxt = (estado == S_OFF) ? S_WLCM : S_OFF;
    end else begin
      case (estado)
        S_WLCM: if (k_st) nxt = S_CH;
        S_CH:   if (k_st) nxt = S_GAME;
        S_GAME: if (w_or_l == 2'b01 || w_or_l == 2'b10) nxt = S_WL;
        S_WL:   if (tick && secs == WL_LAST) nxt = S_PA;
        S_PA: begin
          if (k_yes)                                     nxt = S_GAME;
          else if (k_no)                                 nxt = S_WLCM;
          else if (PA_TO_EN && tick && secs == PA_LAST)  nxt = S_WLCM;
        end
        default: nxt = estado;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kp_q      <= 1'b0;
      estado    <= S_OFF;
      result    <= 2'b00;
      state_chg <= 1'b0;
      secs      <= '0;
      fsm_error <= 1'b0;
      presc     <= '0;
    end else begin
      kp_q      <= keypad_pressed;
      estado    <= nxt;
      state_chg <= chg;
      fsm_error <= fsm_error | err_set;
      // Prescaler phase is tied to state entry so hold times are exact multiples of CLK_HZ.
      presc     <= (chg || tick) ? '0 : presc + PW'(1);
      if (estado == S_GAME && nxt == S_WL) result <= w_or_l;
      else if (!nxt_timed)                 result <= 2'b00;
      if (chg || !in_timed)            secs <= '0;
      else if (tick && secs != 6'd63)  secs <= secs + 6'd1;
    end
  end

endmodule
